// File: rtl/muldiv_ctrl.sv
// Sequencer between EX and the multi-cycle mul/div units; owns the architectural HI/LO pair.
// Latency: start pulse one cycle after issue; HI/LO written on the edge where the unit's end flag is seen.
// Backpressure: stall holds IF..EX from issue until end (or flush/watchdog); mthi/mtlo never stall.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   flush               kill the EX instruction and any in-flight operation
//   ex_valid/ex_op      EX instruction valid and op code (div/divu/mult/multu/mthi/mtlo)
//   ex_op1/ex_op2       rs/rt operands (ex_op1 also feeds mthi/mtlo)
//   stall, timeout      pipeline hold and one-cycle watchdog pulse
//   hi/lo               architectural HI/LO
//   mul_*/div_*         start pulses, signedness, latched operands, results and end flags
// Optional build macro: DIV_ZERO_SHORTCUT_EN (div/divu by zero bypasses the divider).
module muldiv_ctrl #(
  parameter int MAX_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_op1,
  input  logic [31:0] ex_op2,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_start,
  output logic        mul_op,
  output logic        div_start,
  output logic        div_op,
  output logic [31:0] unit_op1,
  output logic [31:0] unit_op2,
  input  logic [63:0] mul_product,
  input  logic        mul_end,
  input  logic [63:0] div_result,
  input  logic        div_end,
  output logic        timeout
);

  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL_WAIT, S_DIV_WAIT, S_DRAIN, S_DZ} state_t;

  state_t        state_q, state_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   unit_op1_q, unit_op1_d, unit_op2_q, unit_op2_d;
  logic          mul_op_q, mul_op_d, div_op_q, div_op_d;
  logic          mul_start_q, mul_start_d, div_start_q, div_start_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drain_div_q, drain_div_d;  // which unit a DRAIN is waiting on

  // Op decode
  logic op_div, op_divu, op_mult, op_multu, op_mthi, op_mtlo;
  logic is_mul, is_div, issue, mt_ok, dz_hit, wd_fire, cur_end, in_wait, commit;

  assign op_div   = (ex_op == 3'b010);
  assign op_divu  = (ex_op == 3'b001);
  assign op_mult  = (ex_op == 3'b110);
  assign op_multu = (ex_op == 3'b101);
  assign op_mthi  = (ex_op == 3'b011);
  assign op_mtlo  = (ex_op == 3'b100);
  assign is_mul   = op_mult | op_multu;
  assign is_div   = op_div | op_divu;
  assign issue    = ex_valid & ~flush & (is_mul | is_div);
  assign mt_ok    = ex_valid & ~flush & ((state_q == S_IDLE) | (state_q == S_DRAIN));
  assign wd_fire  = (cnt_q == CW'(MAX_CYCLES));
  assign in_wait  = (state_q == S_MUL_WAIT) | (state_q == S_DIV_WAIT);

`ifdef DIV_ZERO_SHORTCUT_EN
  assign dz_hit = is_div & (ex_op2 == 32'd0);
`else
  assign dz_hit = 1'b0;
`endif

  // End flag of the unit the current state is listening to; ignored elsewhere.
  always_comb begin
    cur_end = 1'b0;
    case (state_q)
      S_MUL_WAIT: cur_end = mul_end;
      S_DIV_WAIT: cur_end = div_end;
      S_DRAIN:    cur_end = drain_div_q ? div_end : mul_end;
      default:    cur_end = 1'b0;
    endcase
  end

  // A flush in the same cycle as end still discards the result.
  assign commit = in_wait & cur_end & ~flush;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue) state_d = is_mul ? S_MUL_WAIT : (dz_hit ? S_DZ : S_DIV_WAIT);
      end
      S_MUL_WAIT, S_DIV_WAIT: begin
        if (cur_end || wd_fire) state_d = S_IDLE;
        else if (flush)         state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cur_end || wd_fire) state_d = S_IDLE;
      end
      S_DZ:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: stall and watchdog pulse, both forced low while reset is high.
  always_comb begin
    stall   = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE:  stall = issue;
      S_MUL_WAIT, S_DIV_WAIT: begin
        stall   = ~cur_end & ~flush & ~wd_fire;
        timeout = wd_fire & ~cur_end;
      end
      S_DRAIN: begin
        stall   = issue;  // new mul/div waits until the old unit is idle
        timeout = wd_fire & ~cur_end;
      end
      default: stall = 1'b0;
    endcase
    if (reset) begin
      stall   = 1'b0;
      timeout = 1'b0;
    end
  end

  // Datapath next values
  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    unit_op1_d  = unit_op1_q;
    unit_op2_d  = unit_op2_q;
    mul_op_d    = mul_op_q;
    div_op_d    = div_op_q;
    mul_start_d = 1'b0;
    div_start_d = 1'b0;
    cnt_d       = '0;
    drain_div_d = drain_div_q;

    if (state_q == S_IDLE && issue) begin
      unit_op1_d = ex_op1;
      unit_op2_d = ex_op2;
      if (is_mul) begin
        mul_op_d    = op_mult;
        mul_start_d = 1'b1;
      end else begin
        div_op_d    = op_div;
        div_start_d = ~dz_hit;
      end
    end

    if (in_wait || state_q == S_DRAIN) cnt_d = cnt_q + CW'(1);
    if (in_wait) drain_div_d = (state_q == S_DIV_WAIT);

    if (commit) {hi_d, lo_d} = (state_q == S_MUL_WAIT) ? mul_product : div_result;

    if (state_q == S_DZ && !flush) begin
      hi_d = unit_op1_q;
      lo_d = 32'hFFFF_FFFF;
    end

    if (mt_ok && op_mthi) hi_d = ex_op1;
    if (mt_ok && op_mtlo) lo_d = ex_op1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q        <= '0;
      lo_q        <= '0;
      unit_op1_q  <= '0;
      unit_op2_q  <= '0;
      mul_op_q    <= 1'b0;
      div_op_q    <= 1'b0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      cnt_q       <= '0;
      drain_div_q <= 1'b0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      unit_op1_q  <= unit_op1_d;
      unit_op2_q  <= unit_op2_d;
      mul_op_q    <= mul_op_d;
      div_op_q    <= div_op_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
      cnt_q       <= cnt_d;
      drain_div_q <= drain_div_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign unit_op1  = unit_op1_q;
  assign unit_op2  = unit_op2_q;
  assign mul_op    = mul_op_q;
  assign div_op    = div_op_q;
  assign mul_start = mul_start_q;
  assign div_start = div_start_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset, flush, ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_op1, ex_op2;
  logic        stall, mul_start, mul_op, div_start, div_op, timeout;
  logic [31:0] hi, lo, unit_op1, unit_op2;
  logic [63:0] mul_product, div_result;
  logic        mul_end, div_end;

  localparam logic [2:0] OP_DIV = 3'b010, OP_DIVU = 3'b001, OP_MULT = 3'b110,
                         OP_MULTU = 3'b101, OP_MTHI = 3'b011, OP_MTLO = 3'b100;

  muldiv_ctrl #(.MAX_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .stall(stall), .hi(hi), .lo(lo),
    .mul_start(mul_start), .mul_op(mul_op), .div_start(div_start), .div_op(div_op),
    .unit_op1(unit_op1), .unit_op2(unit_op2), .mul_product(mul_product), .mul_end(mul_end),
    .div_result(div_result), .div_end(div_end), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [31:0] m_hi = 32'd0;  // reference HI/LO
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result of one unit operation, from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [31:0] q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      OP_MULT:  return sa * sb;
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = a / b;
        r = a % b;
        return {r, q};
      end
    endcase
  endfunction

  // Issue one mul/div and answer from the bench's unit model after lat wait cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int lat);
    logic        is_mul, sgn;
    logic [63:0] res;
    int          stalls, starts;
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    sgn    = (op == OP_MULT) || (op == OP_DIV);
    res    = ref_result(op, a, b);
    stalls = 0;
    starts = 0;
    @(negedge clk);
    ex_valid = 1'b1; ex_op = op; ex_op1 = a; ex_op2 = b;
    mul_end = 1'b0; div_end = 1'b0;
    mul_product = {$urandom, $urandom}; div_result = {$urandom, $urandom};
    #1;
    chk("issue_stall", stall, 1'b1);
    stalls += int'(stall);
    starts += int'(mul_start) + int'(div_start);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      mul_product = {$urandom, $urandom};
      div_result  = {$urandom, $urandom};
      if (k == lat) begin
        if (is_mul) begin mul_end = 1'b1; mul_product = res; end
        else        begin div_end = 1'b1; div_result  = res; end
      end
      #1;
      stalls += int'(stall);
      starts += int'(mul_start) + int'(div_start);
      chk("start_pulse", is_mul ? mul_start : div_start, k == 1);
      chk("wait_stall", stall, k != lat);
      chk("unit_op1", unit_op1, a);
      chk("unit_op2", unit_op2, b);
      chk("sign_op", is_mul ? mul_op : div_op, sgn);
    end
    @(negedge clk);
    ex_valid = 1'b0; mul_end = 1'b0; div_end = 1'b0;
    #1;
    m_hi = res[63:32];
    m_lo = res[31:0];
    chk("result_hi", hi, m_hi);
    chk("result_lo", lo, m_lo);
    chk("post_stall", stall, 1'b0);
    chk("stall_cycles", stalls, lat);
    chk("start_count", starts, 1);
  endtask

  task automatic do_mt(input logic is_hi, input logic [31:0] v);
    @(negedge clk);
    ex_valid = 1'b1; ex_op = is_hi ? OP_MTHI : OP_MTLO; ex_op1 = v; ex_op2 = $urandom;
    #1;
    chk("mt_stall", stall, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    if (is_hi) m_hi = v; else m_lo = v;
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
  endtask

  initial begin
    logic [2:0]  ops [6];
    logic [2:0]  op;
    logic [31:0] a, b, junk_lo;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

    // Reset for two cycles
    reset = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_op = 3'b000; ex_op1 = '0; ex_op2 = '0;
    mul_product = '0; div_result = '0; mul_end = 1'b0; div_end = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_starts", {mul_start, div_start, timeout}, 3'b000);
    end
    @(negedge clk);
    reset = 1'b0;

    // multu 0xFFFF_FFFF * 2, end four cycles after start
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5);
    chk("multu_lit", {hi, lo}, 64'h1_FFFF_FFFE);

    // div -7 / 2
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 3);
    chk("div_lit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // Flush at wait cycle 2, mthi in DRAIN, later div_end ignored
    @(negedge clk);
    ex_valid = 1'b1; ex_op = OP_DIVU; ex_op1 = 32'd77; ex_op2 = 32'd5; #1;
    chk("fl_issue_stall", stall, 1'b1);
    @(negedge clk); #1;
    chk("fl_start", div_start, 1'b1);
    @(negedge clk);
    flush = 1'b1; #1;
    chk("fl_stall_drop", stall, 1'b0);
    @(negedge clk);
    flush = 1'b0; ex_op = OP_MTHI; ex_op1 = 32'h1234; #1;
    chk("drain_mt_stall", stall, 1'b0);
    @(negedge clk);
    ex_op = OP_DIVU; ex_op1 = 32'd100; ex_op2 = 32'd7; #1;
    m_hi = 32'h1234;
    chk("drain_mthi", hi, m_hi);
    chk("drain_new_stall", stall, 1'b1);
    chk("drain_no_start", div_start, 1'b0);
    @(negedge clk);
    div_end = 1'b1; div_result = {$urandom, $urandom}; #1;
    chk("drain_end_stall", stall, 1'b1);
    chk("drain_no_start2", div_start, 1'b0);
    @(negedge clk);
    div_end = 1'b0; ex_valid = 1'b0; #1;
    chk("drain_hi_kept", hi, m_hi);
    chk("drain_lo_kept", lo, m_lo);
    run_op(OP_DIVU, 32'd100, 32'd7, 2);

    // Watchdog: mul_end withheld
    @(negedge clk);
    ex_valid = 1'b1; ex_op = OP_MULT; ex_op1 = 32'd3; ex_op2 = 32'd4; #1;
    chk("wd_issue", stall, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); #1;
      chk("wd_timeout", timeout, k == 9);
      chk("wd_stall", stall, k != 9);
    end
    @(negedge clk);
    ex_valid = 1'b0; #1;
    chk("wd_pulse_end", timeout, 1'b0);
    chk("wd_hilo", {hi, lo}, {m_hi, m_lo});
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd6, 2);

    // Reset mid-operation
    @(negedge clk);
    ex_valid = 1'b1; ex_op = OP_MULTU; ex_op1 = 32'd9; ex_op2 = 32'd9;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; #1;
    chk("rst_mid_stall", stall, 1'b0);
    @(negedge clk);
    reset = 1'b0; ex_valid = 1'b0; mul_end = 1'b1; mul_product = {$urandom, $urandom}; #1;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("rst_mid_hilo", {hi, lo}, {m_hi, m_lo});
    chk("rst_mid_start", mul_start, 1'b0);
    @(negedge clk);
    mul_end = 1'b0; #1;
    chk("rst_mid_end_ign", {hi, lo}, {m_hi, m_lo});

    // Zero divisor
`ifdef DIV_ZERO_SHORTCUT_EN
    @(negedge clk);
    ex_valid = 1'b1; ex_op = OP_DIVU; ex_op1 = 32'd5; ex_op2 = 32'd0; #1;
    chk("dz_issue_stall", stall, 1'b1);
    @(negedge clk); #1;
    chk("dz_stall", stall, 1'b0);
    chk("dz_no_start", div_start, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0; #1;
    m_hi = 32'd5; m_lo = 32'hFFFF_FFFF;
    chk("dz_result", {hi, lo}, {m_hi, m_lo});
    chk("dz_no_start2", div_start, 1'b0);
`else
    run_op(OP_DIVU, 32'd5, 32'd0, 3);
`endif

    // Randomised sequence
    for (int i = 0; i < 12; i++) begin
      op = ops[$urandom_range(0, 5)];
      a  = $urandom;
      b  = $urandom;
      if (b == 32'd0 || b == 32'hFFFF_FFFF) b = 32'd3;
      junk_lo = $urandom;
      if (op == OP_MTHI || op == OP_MTLO) do_mt(op == OP_MTHI, junk_lo);
      else run_op(op, a, b, $urandom_range(1, 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
